// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Mode encodings travel with each operation down the pipe.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_LSR = 2'b00,
    MODE_LSL = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

endpackage

// File: rtl/shift_stage.sv
// One registered shift level of fixed distance DIST, enabled by
// shamt bit BIT. LSL arrives bit-reversed, so it shifts right here.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int SH_W  = 5,
  parameter int DIST  = 16,
  parameter int BIT   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SH_W-1:0]  in_shamt,
  input  mode_e            in_mode,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_sticky,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SH_W-1:0]  out_shamt,
  output mode_e            out_mode,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_sticky
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SH_W-1:0]  shamt_q, shamt_d;
  mode_e            mode_q, mode_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             sticky_q, sticky_d;

  logic [WIDTH-1:0] shifted;
  logic             lost;

  always_comb begin
    shifted = in_data;
    lost    = 1'b0;
    if (in_shamt[BIT]) begin
      unique case (in_mode)
        MODE_ASR: shifted = WIDTH'($signed(in_data) >>> DIST);
        MODE_ROR: shifted = (in_data >> DIST)
                          | (in_data << (WIDTH - DIST));
        default:  shifted = in_data >> DIST;
      endcase
      lost = (in_mode == MODE_LSR || in_mode == MODE_ASR)
           && (|in_data[DIST-1:0]);
    end
  end

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    shamt_d  = shamt_q;
    mode_d   = mode_q;
    tag_d    = tag_q;
    sticky_d = sticky_q;
    if (adv) begin
      valid_d  = in_valid;
      data_d   = shifted;
      shamt_d  = in_shamt & ~(SH_W'(1) << BIT);
      mode_d   = in_mode;
      tag_d    = in_tag;
      sticky_d = in_sticky | lost;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      shamt_q  <= '0;
      mode_q   <= MODE_LSR;
      tag_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      shamt_q  <= shamt_d;
      mode_q   <= mode_d;
      tag_q    <= tag_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_shamt  = shamt_q;
  assign out_mode   = mode_q;
  assign out_tag    = tag_q;
  assign out_sticky = sticky_q;

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: input register, SH_W shift levels,
// single global advance enable driven by the output handshake.
module barrel_shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SH_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SH_W-1:0]  in_shamt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic [TAG_W-1:0] out_tag
);

  function automatic logic [WIDTH-1:0] rev(
    input logic [WIDTH-1:0] x
  );
    for (int i = 0; i < WIDTH; i++) rev[i] = x[WIDTH-1-i];
  endfunction

  logic adv;
  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;

  logic             v_s  [SH_W+1];
  logic [WIDTH-1:0] d_s  [SH_W+1];
  logic [SH_W-1:0]  sh_s [SH_W+1];
  mode_e            md_s [SH_W+1];
  logic [TAG_W-1:0] tg_s [SH_W+1];
  logic             st_s [SH_W+1];

  logic             v0_q, v0_d;
  logic [WIDTH-1:0] d0_q, d0_d;
  logic [SH_W-1:0]  sh0_q, sh0_d;
  mode_e            md0_q, md0_d;
  logic [TAG_W-1:0] tg0_q, tg0_d;
  mode_e            in_md;

  assign in_md = mode_e'(in_mode);

  always_comb begin
    v0_d  = v0_q;
    d0_d  = d0_q;
    sh0_d = sh0_q;
    md0_d = md0_q;
    tg0_d = tg0_q;
    if (adv) begin
      v0_d  = in_valid;
      d0_d  = (in_md == MODE_LSL) ? rev(in_data) : in_data;
      sh0_d = in_shamt;
      md0_d = in_md;
      tg0_d = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q  <= 1'b0;
      d0_q  <= '0;
      sh0_q <= '0;
      md0_q <= MODE_LSR;
      tg0_q <= '0;
    end else begin
      v0_q  <= v0_d;
      d0_q  <= d0_d;
      sh0_q <= sh0_d;
      md0_q <= md0_d;
      tg0_q <= tg0_d;
    end
  end

  assign v_s[0]  = v0_q;
  assign d_s[0]  = d0_q;
  assign sh_s[0] = sh0_q;
  assign md_s[0] = md0_q;
  assign tg_s[0] = tg0_q;
  assign st_s[0] = 1'b0;

  for (genvar k = 1; k <= SH_W; k++) begin : g_lvl
    shift_stage #(
      .WIDTH(WIDTH),
      .TAG_W(TAG_W),
      .SH_W (SH_W),
      .DIST (1 << (SH_W - k)),
      .BIT  (SH_W - k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv),
      .in_valid  (v_s[k-1]),
      .in_data   (d_s[k-1]),
      .in_shamt  (sh_s[k-1]),
      .in_mode   (md_s[k-1]),
      .in_tag    (tg_s[k-1]),
      .in_sticky (st_s[k-1]),
      .out_valid (v_s[k]),
      .out_data  (d_s[k]),
      .out_shamt (sh_s[k]),
      .out_mode  (md_s[k]),
      .out_tag   (tg_s[k]),
      .out_sticky(st_s[k])
    );
  end

  // All shamt bits are consumed by the last level.
  logic sh_unused;
  assign sh_unused = |sh_s[SH_W];

  assign out_valid  = v_s[SH_W];
  assign out_data   = (md_s[SH_W] == MODE_LSL) ? rev(d_s[SH_W])
                                               : d_s[SH_W];
  assign out_sticky = st_s[SH_W];
  assign out_tag    = tg_s[SH_W];

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe at WIDTH=32, TAG_W=4.
module tb_barrel_shift_pipe;
  import shift_pkg::*;

  localparam int W   = 32;
  localparam int TW  = 4;
  localparam int LAT = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_data, out_data;
  logic [4:0]    in_shamt;
  logic [1:0]    in_mode;
  logic [TW-1:0] in_tag, out_tag;
  logic          out_valid, out_ready, out_sticky;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [W-1:0]  d;
    logic          s;
    logic [TW-1:0] t;
  } res_t;

  res_t exp_q[$];
  int   cons_cyc[$];
  int   cons_tag[$];

  logic          hv = 1'b0;
  logic [W-1:0]  hd;
  logic          hs;
  logic [TW-1:0] ht;

  always #5 clk = ~clk;

  barrel_shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sticky(out_sticky),
    .out_tag   (out_tag)
  );

  function automatic res_t model(
    input logic [W-1:0] d, input int s,
    input logic [1:0] m, input logic [TW-1:0] t
  );
    res_t r;
    logic [63:0] lost;
    r.t  = t;
    r.s  = 1'b0;
    lost = (s == 0) ? 64'd0 : ({32'd0, d} & ((64'd1 << s) - 64'd1));
    case (m)
      2'b00: begin r.d = d >> s; r.s = |lost; end
      2'b01: r.d = d << s;
      2'b10: begin r.d = W'($signed(d) >>> s); r.s = |lost; end
      default: r.d = (s == 0) ? d : ((d >> s) | (d << (W - s)));
    endcase
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      hv = 1'b0;
    end else begin
      if (hv) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hd);
        chk("hold_sticky", out_sticky, hs);
        chk("hold_tag", out_tag, ht);
      end
      hv = out_valid && !out_ready;
      hd = out_data;
      hs = out_sticky;
      ht = out_tag;
      if (out_valid && out_ready) begin
        cons_cyc.push_back(cyc);
        cons_tag.push_back(int'(out_tag));
        if (exp_q.size() == 0) begin
          chk("no_extra_result", out_valid, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_sticky", out_sticky, e.s);
          chk("sb_tag", out_tag, e.t);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_data, int'(in_shamt), in_mode, in_tag));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic dir_op(input string nm, input logic [W-1:0] d,
                        input int s, input logic [1:0] m,
                        input logic [TW-1:0] t,
                        input logic [W-1:0] ed, input logic es);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = 5'(s);
    in_mode   = m;
    in_tag    = t;
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, n, LAT);
    chk({nm, "_data"}, out_data, ed);
    chk({nm, "_sticky"}, out_sticky, es);
    chk({nm, "_tag"}, out_tag, t);
    step();
  endtask

  task automatic rand_in(input logic [TW-1:0] t);
    in_data  = $urandom;
    in_shamt = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
    in_mode  = 2'($urandom);
    in_tag   = t;
  endtask

  initial begin
    int n;
    res_t r;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0;
    in_mode = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sticky", out_sticky, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);

    dir_op("lsr1", 32'h80000001, 1, MODE_LSR, 4'd3, 32'h40000000, 1'b1);
    dir_op("lsl4", 32'h80000001, 4, MODE_LSL, 4'd5, 32'h00000010, 1'b0);
    dir_op("ror1", 32'h00000001, 1, MODE_ROR, 4'd6, 32'h80000000, 1'b0);
    dir_op("asr31a", 32'h80000000, 31, MODE_ASR, 4'd7,
           32'hFFFFFFFF, 1'b0);
    dir_op("asr31b", 32'h7FFFFFFF, 31, MODE_ASR, 4'd8,
           32'h00000000, 1'b1);
    dir_op("sh0_asr", 32'hA5A5F00F, 0, MODE_ASR, 4'd9,
           32'hA5A5F00F, 1'b0);
    dir_op("sh0_lsl", 32'h12345678, 0, MODE_LSL, 4'd10,
           32'h12345678, 1'b0);
    dir_op("lsl31", 32'h00000003, 31, MODE_LSL, 4'd11,
           32'h80000000, 1'b0);

    // back-to-back throughput
    cons_cyc.delete();
    cons_tag.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      rand_in(TW'(i));
      step();
    end
    in_valid = 1'b0;
    repeat (10) step();
    chk("b2b_count", cons_cyc.size(), 8);
    for (int i = 0; i < 8 && i < cons_cyc.size(); i++) begin
      chk("b2b_consecutive", cons_cyc[i] - cons_cyc[0], i);
      chk("b2b_order", cons_tag[i], i);
    end

    // backpressure fill and drain
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      rand_in(TW'(i));
      step();
    end
    chk("fill_in_ready", in_ready, 0);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_depth", exp_q.size(), LAT);
    chk("fill_first_tag", out_tag, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      step();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) step();

    // reset with operations in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      rand_in(TW'(i + 4));
      step();
    end
    rst = 1'b1;
    rand_in(4'hF);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_flush_valid", out_valid, 0);
      step();
    end
    r = model(32'hDEADBEEF, 13, MODE_ASR, 4'd12);
    dir_op("post_rst", 32'hDEADBEEF, 13, MODE_ASR, 4'd12, r.d, r.s);

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      rand_in(TW'($urandom));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      step();
      n++;
    end
    chk("rand_drain_empty", exp_q.size(), 0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
